baud_tick_ctrl: RTL

Run-time controller for the UART baud timebase. It holds the active clock divisor and accepts divisor updates from the config interface through a load/ack handshake. Updates are applied only on a bit boundary, so a bit in flight is never stretched or shortened. It emits an oversample tick, a bit-centre tick and a bit-end tick for the TX/RX engines.

---
 rtl/baud_tick_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/baud_tick_ctrl.sv
// UART baud timebase: oversample / bit-centre / bit-end ticks with a
// run-time divisor that only changes on a bit boundary.
module baud_tick_ctrl #(
  parameter int unsigned DIV_W         = 11,
  parameter int unsigned DEFAULT_DIVSR = 650,
  parameter int unsigned OVS           = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] cfg_divsr_i,
  input  logic             cfg_load_i,
  output logic             cfg_busy_o,
  output logic             cfg_ack_o,
  output logic             ovs_tick_o,
  output logic             mid_tick_o,
  output logic             bit_tick_o,
  output logic             running_o,
  output logic [DIV_W-1:0] div_o
);

  localparam int unsigned IW = $clog2(OVS);
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIVSR);
  localparam logic [IW-1:0] MID_IDX = IW'(OVS/2 - 1);
  localparam logic [IW-1:0] END_IDX = IW'(OVS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [IW-1:0]    idx;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_p;
  logic             pend;
  logic             ack_q;

  assign ovs_tick_o = (state == RUN) && (cnt == div_q);
  assign mid_tick_o = ovs_tick_o && (idx == MID_IDX);
  assign bit_tick_o = ovs_tick_o && (idx == END_IDX);
  assign running_o  = (state == RUN);
  assign cfg_busy_o = pend;
  assign cfg_ack_o  = ack_q;
  assign div_o      = div_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      div_q <= DEF;
      div_p <= '0;
      pend  <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_load_i) begin
            div_q <= cfg_divsr_i;
            ack_q <= 1'b1;
          end
          if (en_i) begin
            state <= RUN;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          if (!en_i) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            // a pending update must not be lost when the timebase stops
            if (cfg_load_i || pend) begin
              div_q <= cfg_load_i ? cfg_divsr_i : div_p;
              pend  <= 1'b0;
              ack_q <= 1'b1;
            end
          end else begin
            if (ovs_tick_o) begin
              cnt <= '0;
              idx <= (idx == END_IDX) ? '0 : idx + IW'(1);
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
            if (bit_tick_o && (cfg_load_i || pend)) begin
              div_q <= cfg_load_i ? cfg_divsr_i : div_p;
              pend  <= 1'b0;
              ack_q <= 1'b1;
            end else if (cfg_load_i) begin
              div_p <= cfg_divsr_i;
              pend  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
